pool_window_sched: RTL and testbench

//  Sequencer for the pooling datapath. Walks stride x stride windows over one LENPSUM x LENPSUM psum tile
//  in the PE-level buffer, issuing one read address per cycle plus window first/last/valid strobes.

---
 rtl/pool_pkg.sv | 15 +
 rtl/pool_window_sched_if.sv | 33 +++
 rtl/pool_win_cnt.sv | 50 +++++
 rtl/pool_window_sched.sv | 103 ++++++++++
 tb/tb_pool_window_sched.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared constants, state encoding and window-count helper for pool_window_sched
package pool_pkg;
  localparam int LENPSUM = 14;
  localparam int FL_MAX = 21;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_LAST = 3'd4;
  localparam logic [1:0] STRIDE2 = 2'd2;
  localparam logic [1:0] STRIDE3 = 2'd3;
  function automatic int nwin(input int len, input logic [1:0] s);
    return (s == STRIDE3) ? len / 3 : len / 2;
  endfunction
endpackage

// File: rtl/pool_window_sched_if.sv
// pool_window_sched_if: layer-control / pool-datapath bundle around the window scheduler
// master drives cfg_*, start, pel_rdy, ds_rdy; slave (the scheduler) drives the read,
// window, frame-pool and status strobes.
interface pool_window_sched_if #(
  parameter int ADDR_W = 8,
  parameter int FRM_W = 6,
  parameter int FL_W = 5
);
  logic [1:0] cfg_stride;
  logic [FL_W-1:0] cfg_fl;
  logic cfg_frm;
  logic start;
  logic pel_rdy;
  logic ds_rdy;
  logic pel_en_rd;
  logic [ADDR_W-1:0] pel_addr_rd;
  logic win_first;
  logic win_vld;
  logic [FL_W-1:0] fl_out;
  logic frm_en_rd;
  logic [FRM_W-1:0] frm_addr;
  logic busy;
  logic done;
  logic cfg_err;
  modport master (
    output cfg_stride, cfg_fl, cfg_frm, start, pel_rdy, ds_rdy,
    input pel_en_rd, pel_addr_rd, win_first, win_vld, fl_out, frm_en_rd, frm_addr, busy, done, cfg_err
  );
  modport slave (
    input cfg_stride, cfg_fl, cfg_frm, start, pel_rdy, ds_rdy,
    output pel_en_rd, pel_addr_rd, win_first, win_vld, fl_out, frm_en_rd, frm_addr, busy, done, cfg_err
  );
endinterface

// File: rtl/pool_win_cnt.sv
// pool_win_cnt: in-window (cx,cy) and window-base (col,row) counters producing the PEL read address
// Ports: clr zeroes all counters, adv steps one read, stride is already legalised (2 or 3);
// addr is the current read address, win_first/win_end/tile_end flag the current read's position.
module pool_win_cnt #(
  parameter int LENPSUM = pool_pkg::LENPSUM,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  input  logic [1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic win_first,
  output logic win_end,
  output logic tile_end
);
  import pool_pkg::*;
  logic [1:0] cx_q, cx_d, cy_q, cy_d, sm1;
  logic [ADDR_W-1:0] col_q, col_d, row_q, row_d;
  logic col_last, row_last;
  always_comb begin
    sm1 = stride - 2'd1;
    col_last = col_q == ADDR_W'((nwin(LENPSUM, stride) - 1) * int'(stride));
    row_last = row_q == ADDR_W'((nwin(LENPSUM, stride) - 1) * int'(stride) * LENPSUM);
    win_first = cx_q == 2'd0 && cy_q == 2'd0;
    win_end = cx_q == sm1 && cy_q == sm1;
    tile_end = win_end && col_last && row_last;
    addr = row_q + col_q + ADDR_W'(cy_q) * ADDR_W'(LENPSUM) + ADDR_W'(cx_q);
    cx_d = clr ? 2'd0 : !adv ? cx_q : cx_q == sm1 ? 2'd0 : cx_q + 2'd1;
    cy_d = clr ? 2'd0 : (!adv || cx_q != sm1) ? cy_q : cy_q == sm1 ? 2'd0 : cy_q + 2'd1;
    col_d = clr ? '0 : !(adv && win_end) ? col_q : col_last ? '0 : col_q + ADDR_W'(stride);
    // row wraps to 0 after the final window so an idle scheduler presents address 0
    row_d = clr ? '0 : !(adv && win_end && col_last) ? row_q :
            row_last ? '0 : row_q + ADDR_W'(stride) * ADDR_W'(LENPSUM);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= 2'd0;
      cy_q <= 2'd0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/pool_window_sched.sv
// pool_window_sched: walks stride x stride windows over a LENPSUM^2 psum tile for the pooling datapath
// Ports: clk, reset (sync, active-high), p (slave side of pool_window_sched_if: cfg/start/pel_rdy/ds_rdy
// in; pel read, window strobes, fl_out, frame-pool addressing, busy/done/cfg_err out).
// POOL_SCHED_FRMPOOL_EN enables frame-pool read strobe and window-index addressing.
module pool_window_sched #(
  parameter int LENPSUM = pool_pkg::LENPSUM,
  parameter int ADDR_W = 8,
  parameter int FRM_W = 6,
  parameter int FL_W = 5,
  parameter int FL_MAX = pool_pkg::FL_MAX
) (
  input logic clk,
  input logic reset,
  pool_window_sched_if.slave p
);
  import pool_pkg::*;
  logic [2:0] state_q, state_d;
  logic [1:0] stride_q, stride_d;
  logic [FL_W-1:0] fl_q, fl_d;
  logic err_q, err_d, vld_q, vld_d, done_q, done_d;
  logic rd, clr, take, wfirst, wend, tend;
  logic [ADDR_W-1:0] addr;
  pool_win_cnt #(.LENPSUM(LENPSUM), .ADDR_W(ADDR_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .adv(rd),
    .stride(stride_q),
    .addr(addr),
    .win_first(wfirst),
    .win_end(wend),
    .tile_end(tend)
  );
  always_comb begin
    take = state_q == S_IDLE && p.start;
    clr = state_q == S_LOAD;
    rd = state_q == S_READ && p.pel_rdy;
    stride_d = take ? (p.cfg_stride == STRIDE3 ? STRIDE3 : STRIDE2) : stride_q;
    fl_d = take ? (p.cfg_fl > FL_W'(FL_MAX) ? FL_W'(FL_MAX) : p.cfg_fl) : fl_q;
    err_d = take ? p.cfg_stride < STRIDE2 : err_q;
    // a window-end read always counts; READ vs HOLD then depends on ds_rdy alone
    state_d = state_q == S_IDLE ? (p.start ? S_LOAD : S_IDLE) :
              state_q == S_LOAD ? S_READ :
              state_q == S_HOLD ? (p.ds_rdy ? S_READ : S_HOLD) :
              state_q == S_READ ? (!(rd && wend) ? S_READ : tend ? S_LAST : p.ds_rdy ? S_READ : S_HOLD) :
              S_IDLE;
    vld_d = rd && wend;
    done_d = state_q == S_LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stride_q <= STRIDE2;
      fl_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stride_q <= stride_d;
      fl_q <= fl_d;
      err_q <= err_d;
      vld_q <= vld_d;
      done_q <= done_d;
    end
  end
  assign p.pel_en_rd = rd;
  assign p.pel_addr_rd = addr;
  assign p.win_first = rd && wfirst;
  assign p.win_vld = vld_q;
  assign p.fl_out = fl_q;
  assign p.busy = state_q != S_IDLE;
  assign p.done = done_q;
  assign p.cfg_err = err_q;
`ifdef POOL_SCHED_FRMPOOL_EN
  logic frm_q, frm_d, fen_q, fen_d;
  logic [FRM_W-1:0] fa_q, fa_d;
  always_comb begin
    frm_d = take ? p.cfg_frm : frm_q;
    fen_d = rd && wend && frm_q;
    // the index steps after each pooled result but holds on the final window
    fa_d = clr ? '0 : (vld_q && state_q != S_LAST) ? fa_q + FRM_W'(1) : fa_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_q <= 1'b0;
      fen_q <= 1'b0;
      fa_q <= '0;
    end else begin
      frm_q <= frm_d;
      fen_q <= fen_d;
      fa_q <= fa_d;
    end
  end
  assign p.frm_en_rd = fen_q;
  assign p.frm_addr = fa_q;
`else
  logic unused_frm;
  assign unused_frm = p.cfg_frm;
  assign p.frm_en_rd = 1'b0;
  assign p.frm_addr = FRM_W'(0);
`endif
endmodule

// File: tb/tb_pool_window_sched.sv
// tb_pool_window_sched: randomized self-checking bench against a window-walk reference model
module tb_pool_window_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pool_window_sched_if #(.ADDR_W(8), .FRM_W(6), .FL_W(5)) bus ();
  pool_window_sched dut (.clk(clk), .reset(reset), .p(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string pfx);
    chk({pfx, "_en"}, 32'(bus.pel_en_rd), 0);
    chk({pfx, "_addr"}, 32'(bus.pel_addr_rd), 0);
    chk({pfx, "_first"}, 32'(bus.win_first), 0);
    chk({pfx, "_vld"}, 32'(bus.win_vld), 0);
    chk({pfx, "_fl"}, 32'(bus.fl_out), 0);
    chk({pfx, "_frm_en"}, 32'(bus.frm_en_rd), 0);
    chk({pfx, "_frm_addr"}, 32'(bus.frm_addr), 0);
    chk({pfx, "_busy"}, 32'(bus.busy), 0);
    chk({pfx, "_done"}, 32'(bus.done), 0);
    chk({pfx, "_err"}, 32'(bus.cfg_err), 0);
  endtask

  task automatic frm_chk(input bit vld, input bit frm, input int widx);
`ifdef POOL_SCHED_FRMPOOL_EN
    chk("frm_en", 32'(bus.frm_en_rd), 32'(vld && frm));
    if (vld) chk("frm_addr", 32'(bus.frm_addr), widx);
`else
    chk("frm_en", 32'(bus.frm_en_rd), 32'(1'b0 & frm));
    chk("frm_addr", 32'(bus.frm_addr), 32'(vld & 1'b0) + 32'(widx & 0));
`endif
  endtask

  task automatic run_tile(input logic [1:0] cs, input logic [4:0] cf, input bit cfrm,
                          input int pr_pct, input int dr_pct, input int plo_rd,
                          input int dlo_rd, input int abort_rd, input int exp_lat);
    int s, nw, total, rd, widx, load_c, iter, plo_left, dlo_left;
    bit vld_due, exp_en, pr, dr, blk;
    int q[$];
    logic [4:0] fl_exp;
    bit err_exp;
    s = (cs == 2'd3) ? 3 : 2;
    nw = 14 / s;
    total = nw * nw * s * s;
    for (int wy = 0; wy < nw; wy++)
      for (int wx = 0; wx < nw; wx++)
        for (int cy = 0; cy < s; cy++)
          for (int cx = 0; cx < s; cx++)
            q.push_back((wy * s + cy) * 14 + wx * s + cx);
    fl_exp = (cf > 5'd21) ? 5'd21 : cf;
    err_exp = cs < 2'd2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_stride = cs;
    bus.cfg_fl = cf;
    bus.cfg_frm = cfrm;
    bus.pel_rdy = 1'($urandom_range(1));
    bus.ds_rdy = 1'($urandom_range(1));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    load_c = cyc;
    chk("load_busy", 32'(bus.busy), 1);
    chk("load_en", 32'(bus.pel_en_rd), 0);
    chk("load_vld", 32'(bus.win_vld), 0);
    chk("load_done", 32'(bus.done), 0);
    chk("cfg_err", 32'(bus.cfg_err), 32'(err_exp));
    chk("fl_out", 32'(bus.fl_out), 32'(fl_exp));
    rd = 0;
    widx = 0;
    vld_due = 1'b0;
    blk = 1'b0;
    plo_left = 5;
    dlo_left = 4;
    iter = 0;
    while (rd < total && iter < 6000) begin
      iter++;
      if (abort_rd >= 0 && rd == abort_rd) begin
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        idle_chk("abort");
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("abort_done", 32'(bus.done), 0);
          chk("abort_busy", 32'(bus.busy), 0);
        end
        return;
      end
      @(negedge clk);
      pr = $urandom_range(99) < 32'(pr_pct);
      dr = $urandom_range(99) < 32'(dr_pct);
      if (rd == plo_rd && plo_left > 0) begin
        pr = 1'b0;
        plo_left--;
      end
      if ((rd == dlo_rd || dlo_left < 4) && dlo_left > 0) begin
        dr = 1'b0;
        dlo_left--;
      end
      bus.pel_rdy = pr;
      bus.ds_rdy = dr;
      bus.start = $urandom_range(7) == 0;
      bus.cfg_stride = 2'($urandom_range(3));
      bus.cfg_fl = 5'($urandom_range(31));
      bus.cfg_frm = 1'($urandom_range(1));
      #1;
      exp_en = !blk && pr;
      chk("pel_en_rd", 32'(bus.pel_en_rd), 32'(exp_en));
      chk("win_first", 32'(bus.win_first), 32'(exp_en && (rd % (s * s) == 0)));
      chk("win_vld", 32'(bus.win_vld), 32'(vld_due));
      chk("busy", 32'(bus.busy), 1);
      chk("done_early", 32'(bus.done), 0);
      chk("fl_hold", 32'(bus.fl_out), 32'(fl_exp));
      chk("err_hold", 32'(bus.cfg_err), 32'(err_exp));
      frm_chk(vld_due, cfrm, widx);
      if (vld_due) widx++;
      if (exp_en) chk("pel_addr", 32'(bus.pel_addr_rd), q[rd]);
      vld_due = exp_en && ((rd + 1) % (s * s) == 0);
      if (exp_en) begin
        rd++;
        if (vld_due && rd < total && !dr) blk = 1'b1;
      end else if (blk && dr) blk = 1'b0;
    end
    chk("reads", rd, total);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("last_vld", 32'(bus.win_vld), 32'(vld_due));
    chk("last_en", 32'(bus.pel_en_rd), 0);
    chk("last_busy", 32'(bus.busy), 1);
    chk("last_done", 32'(bus.done), 0);
    frm_chk(vld_due, cfrm, widx);
    @(negedge clk);
    #1;
    chk("done", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_vld", 32'(bus.win_vld), 0);
    if (exp_lat > 0) chk("latency", cyc - load_c, exp_lat);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(bus.done), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_stride = 2'd0;
    bus.cfg_fl = 5'd0;
    bus.cfg_frm = 1'b0;
    bus.pel_rdy = 1'b0;
    bus.ds_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    idle_chk("reset");
    reset = 1'b0;
    run_tile(2'd2, 5'd10, 1'b1, 100, 100, -1, -1, -1, 198);
    run_tile(2'd3, 5'd7, 1'b1, 100, 100, -1, -1, -1, 146);
    run_tile(2'd2, 5'd3, 1'b0, 100, 100, 6, 15, -1, 0);
    run_tile(2'd1, 5'd25, 1'b1, 70, 70, -1, -1, -1, 0);
    run_tile(2'd2, 5'd5, 1'b1, 80, 60, -1, -1, -1, 0);
    run_tile(2'd3, 5'd30, 1'b1, 75, 75, -1, -1, -1, 0);
    run_tile(2'd2, 5'd9, 1'b1, 100, 100, -1, -1, 50, 0);
    run_tile(2'd2, 5'd12, 1'b1, 100, 100, -1, -1, -1, 198);
    run_tile(2'd0, 5'd21, 1'b0, 60, 80, -1, -1, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
